packet_channel_fifo: RTL and testbench
======================================

PACKET_CHANNEL_FIFO -- requirements
Module: packet_channel_fifo

Interface
REQ-001 Parameter PAYLOAD_W, default 8, payload width in bits (>=1).
REQ-002 Parameter CH_W, default 2, channel field width in bits (1..4).
REQ-003 Parameter DEPTH, default 4, packet entries; power of two, >=2.
REQ-004 Parameter XFORM, default 1: 1 = output transform enabled, 0 = packets pass unmodified.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream packet present.
REQ-008 in_ready  output  1  block can accept a packet this cycle.
REQ-009 in_payload  input  PAYLOAD_W  upstream payload.
REQ-010 in_channel  input  CH_W  upstream channel.
REQ-011 ch_mask  input  2**CH_W  bit c = 1: packets on channel c are dropped.
REQ-012 flush  input  1  synchronous clear of queued packets.
REQ-013 out_valid  output  1  head packet present.
REQ-014 out_ready  input  1  downstream accepts head packet.
REQ-015 out_payload  output  PAYLOAD_W  head payload (transformed per XFORM).
REQ-016 out_channel  output  CH_W  head channel (transformed per XFORM).
REQ-017 count  output  clog2(DEPTH+1)  number of stored packets.
REQ-018 drop_count  output  16  number of masked packets dropped, saturating.

Function
REQ-019 Push SHALL occur when in_valid && in_ready.
REQ-020 Pop SHALL occur when out_valid && out_ready.
REQ-021 in_ready SHALL be 1 iff count < DEPTH and flush = 0, derived from registered state and flush only, with no dependence on out_ready.
REQ-022 out_valid SHALL be 1 iff count != 0.
REQ-023 A push with ch_mask[in_channel] = 1 SHALL consume the packet without storing it, leave count unchanged by that push, and increment drop_count by 1, saturating at 16'hFFFF.
REQ-024 A push with ch_mask[in_channel] = 0 SHALL write {in_payload, in_channel} at the write pointer and advance the write pointer modulo DEPTH.
REQ-025 A pop SHALL advance the read pointer modulo DEPTH.
REQ-026 There SHALL be no bypass path: a stored packet SHALL appear at the outputs no earlier than the cycle after its push.
REQ-027 Ordering SHALL be strict FIFO across all channels.
REQ-028 count update:
- stored push without pop: +1
- pop without stored push: -1
- stored push with pop: unchanged
- dropped push with pop: -1
REQ-029 With XFORM = 1 (output transform):
- out_payload = (stored payload + 1) mod 2**PAYLOAD_W; all-ones SHALL wrap to 0.
- out_channel = stored channel XOR all-ones.
REQ-030 With XFORM = 0, out_payload and out_channel SHALL equal the stored fields.
REQ-031 When out_valid = 0, out_payload and out_channel SHALL be driven to 0.
REQ-032 While out_valid = 1 and no pop occurs, out_payload and out_channel SHALL remain stable (barring flush or rst).
REQ-033 ch_mask SHALL be sampled only at push time; changing ch_mask SHALL not affect packets already stored.
REQ-034 When full (count = DEPTH), in_ready SHALL be 0 even if out_ready = 1 in the same cycle.
REQ-035 Flush SHALL take priority over pop:
- next cycle: count = 0, both pointers = 0, out_valid = 0.
- drop_count unchanged.
- no pop is counted in the flush cycle.

Reset
REQ-036 On rst = 1 at a clock edge, the block SHALL set count = 0, both pointers = 0 and drop_count = 0, giving in_ready = 1, out_valid = 0, out_payload = 0 and out_channel = 0 from the following cycle.
REQ-037 rst SHALL take priority over flush, push and pop in the same cycle.
REQ-038 Storage array contents are not reset and SHALL never be observable while out_valid = 0.
REQ-039 rst asserted mid-stream SHALL discard all queued packets with no output of partial state.

Verification
REQ-040 The bench SHALL cover these scenarios (default parameters, XFORM = 1):
- Fill then drain: push payloads 8'h10..8'h13 on channel 2'b01 with out_ready = 0 -> count = 4, in_ready = 0. Then drain -> outputs 8'h11..8'h14, channel 2'b10, in order.
- Wrap: push 8'hFF on channel 2'b00 -> out_payload = 8'h00, out_channel = 2'b11. Then 10 continuous push+pop cycles -> count constant, pointers wrap, order preserved.
- Mask: ch_mask = 4'b0100, push 3 packets on channel 2'b10 and 1 packet on channel 2'b00 -> count = 1, drop_count = 3. Then preload drop_count to saturation -> stays 16'hFFFF.
- Full with out_ready = 1: in_ready = 0 while full -> pop completes and count = 3; in_ready = 1 the next cycle.
- Flush with 3 packets queued and out_ready = 1 in the same cycle -> next cycle count = 0, out_valid = 0, out_payload = 0, drop_count unchanged.
- rst asserted with 2 packets queued and in_valid = 1 -> next cycle count = 0, drop_count = 0, out_valid = 0, and no packet accepted.

Source files
------------

// File: rtl/packet_channel_fifo.sv
// Packet FIFO with per-channel drop mask, saturating drop counter and an
// optional output transform (payload + 1, channel inverted). Strict FIFO
// order across channels, no bypass: a stored packet is visible the cycle
// after its push at the earliest.
module packet_channel_fifo #(
    parameter int unsigned PAYLOAD_W = 8,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned XFORM     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    input  logic [CH_W-1:0]              in_channel,
    input  logic [(1 << CH_W)-1:0]       ch_mask,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PAYLOAD_W-1:0]         out_payload,
    output logic [CH_W-1:0]              out_channel,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [15:0]                  drop_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [CH_W-1:0]      channel;
    } entry_t;

    // Storage is deliberately left unreset; it is only visible while count != 0.
    entry_t             mem_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [15:0]        drop_q,   drop_d;

    logic               push_c;
    logic               masked_c;
    logic               store_c;
    logic               pop_c;
    entry_t             head_c;

    // Handshake decode: ready looks only at registered fill level and flush.
    always_comb begin
        in_ready  = (count_q < CNT_W'(DEPTH)) && !flush;
        out_valid = (count_q != '0);
        push_c    = in_valid && in_ready;
        masked_c  = ch_mask[in_channel];
        store_c   = push_c && !masked_c;
        pop_c     = out_valid && out_ready && !flush;
    end

    // Next-state for pointers, fill level and drop counter; flush wins over pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({store_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (push_c && masked_c && (drop_q != 16'hFFFF)) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    // Control state register; reset overrides flush, push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Packet storage write; mask is sampled here only, never re-applied later.
    always_ff @(posedge clk) begin
        if (store_c && !rst) begin
            mem_q[wr_ptr_q] <= '{payload: in_payload, channel: in_channel};
        end
    end

    // Head presentation: zero when empty, optionally transformed when valid.
    always_comb begin
        head_c      = mem_q[rd_ptr_q];
        out_payload = '0;
        out_channel = '0;
        if (out_valid) begin
            if (XFORM != 0) begin
                out_payload = head_c.payload + PAYLOAD_W'(1);
                out_channel = ~head_c.channel;
            end else begin
                out_payload = head_c.payload;
                out_channel = head_c.channel;
            end
        end
    end

    assign count      = count_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_packet_channel_fifo.sv
// Self-checking bench for packet_channel_fifo (default parameters, XFORM = 1).
// A reference queue holds expected transformed packets, pushed on accepted
// stores and popped when the DUT hands a packet downstream.
module tb_packet_channel_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_payload;
    logic [1:0]  in_channel;
    logic [3:0]  ch_mask;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_payload;
    logic [1:0]  out_channel;
    logic [2:0]  count;
    logic [15:0] drop_count;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [9:0]  exp_q [$];
    logic [15:0] mdl_drop;

    packet_channel_fifo #(
        .PAYLOAD_W(8),
        .CH_W     (2),
        .DEPTH    (4),
        .XFORM    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_payload (in_payload),
        .in_channel (in_channel),
        .ch_mask    (ch_mask),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_payload(out_payload),
        .out_channel(out_channel),
        .count      (count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare all outputs against the model at negedge, then advance model.
    task automatic cycle();
        logic       exp_rdy;
        logic       exp_vld;
        logic [9:0] head;
        @(negedge clk);
        exp_rdy = (exp_q.size() < 4) && !flush;
        exp_vld = (exp_q.size() != 0);
        head    = exp_vld ? exp_q[0] : 10'd0;
        check("in_ready",    32'(in_ready),    32'(exp_rdy));
        check("out_valid",   32'(out_valid),   32'(exp_vld));
        check("out_payload", 32'(out_payload), 32'(head[9:2]));
        check("out_channel", 32'(out_channel), 32'(head[1:0]));
        check("count",       32'(count),       32'(exp_q.size()));
        check("drop_count",  32'(drop_count),  32'(mdl_drop));
        if (rst) begin
            exp_q.delete();
            mdl_drop = 16'd0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            if (exp_vld && out_ready) begin
                void'(exp_q.pop_front());
            end
            if (in_valid && exp_rdy) begin
                if (ch_mask[in_channel]) begin
                    if (mdl_drop != 16'hFFFF) mdl_drop = mdl_drop + 16'd1;
                end else begin
                    exp_q.push_back({8'(in_payload + 8'd1), ~in_channel});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_payload = 8'd0;
        in_channel = 2'd0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic push(input logic [7:0] p, input logic [1:0] c, input logic ordy);
        in_valid   = 1'b1;
        in_payload = p;
        in_channel = c;
        out_ready  = ordy;
        cycle();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        ch_mask  = 4'b0000;
        mdl_drop = 16'd0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        cycle();

        // Fill then drain
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 2'b01, 1'b0);
        cycle();
        check("fill_count", 32'(count), 32'd4);
        check("fill_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("drain_payload", 32'(out_payload), 32'(8'h11 + 8'(i)));
            check("drain_channel", 32'(out_channel), 32'(2'b10));
            drain(1);
        end
        cycle();

        // Wrap of payload and pointers
        push(8'hFF, 2'b00, 1'b0);
        check("wrap_payload", 32'(out_payload), 32'h00);
        check("wrap_channel", 32'(out_channel), 32'(2'b11));
        for (int i = 0; i < 10; i++) push(8'h40 + 8'(i), 2'(i), 1'b1);
        check("stream_count", 32'(count), 32'd1);
        drain(2);

        // Full with out_ready = 1: no push while full, pop completes
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 2'b11, 1'b0);
        push(8'hB0, 2'b10, 1'b1);
        check("full_pop_count", 32'(count), 32'd3);
        check("full_ready_next", 32'(in_ready), 32'd1);
        drain(4);

        // Flush with 3 queued and out_ready high
        ch_mask = 4'b1000;
        push(8'h01, 2'b11, 1'b0);
        ch_mask = 4'b0000;
        for (int i = 0; i < 3; i++) push(8'h20 + 8'(i), 2'b00, 1'b0);
        flush     = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_payload", 32'(out_payload), 32'd0);
        check("flush_drop", 32'(drop_count), 32'd1);

        // Mask: 3 dropped on channel 2, 1 stored on channel 0
        ch_mask = 4'b0100;
        for (int i = 0; i < 3; i++) push(8'h30 + 8'(i), 2'b10, 1'b0);
        push(8'h55, 2'b00, 1'b0);
        check("mask_count", 32'(count), 32'd1);
        check("mask_drop", 32'(drop_count), 32'd4);
        // Changing the mask must not affect the stored packet
        ch_mask = 4'b1111;
        cycle();
        check("mask_late_payload", 32'(out_payload), 32'h56);

        // Saturate drop counter
        in_valid   = 1'b1;
        in_channel = 2'b01;
        for (int i = 0; i < 65535; i++) begin
            in_payload = 8'(i);
            cycle();
        end
        in_valid = 1'b0;
        check("sat_drop", 32'(drop_count), 32'hFFFF);
        check("sat_count", 32'(count), 32'd1);
        ch_mask = 4'b0000;

        // Reset mid-stream with a push offered
        push(8'h66, 2'b01, 1'b0);
        in_valid   = 1'b1;
        in_payload = 8'h77;
        in_channel = 2'b00;
        rst        = 1'b1;
        cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        cycle();

        // Post-reset sanity
        push(8'h7F, 2'b10, 1'b0);
        drain(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
